ysyx_pcgen: RTL
===============

# ysyx_pcgen

Parametrised program-counter generator for the ysyx front end. It produces aligned fetch groups of `FETCH_W` instructions to the IFU under a valid/ready handshake. It arbitrates prioritised redirects from trap, commit flush and branch prediction. It keeps a `RAS_DEPTH`-entry return-address stack that supplies predicted return targets.

## Interface
Parameters:
- `XLEN`, 32: address width.
- `PC_INIT`, 32'h8000_0000: reset vector. Bits [1:0] must be 0.
- `FETCH_W`, 2: instructions per fetch group. Power of 2, range 1..4. Group size is `G = FETCH_W*4` bytes.
- `RAS_DEPTH`, 4: return-stack entries. Power of 2, at least 2.

Ports:
- `clk` in 1: clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `trap_valid` in 1: trap/xret redirect request.
- `trap_pc` in XLEN: trap target.
- `flush_valid` in 1: commit-side misspeculation redirect.
- `flush_pc` in XLEN: flush target.
- `bpu_valid` in 1: predicted-taken redirect for the current group.
- `bpu_pc` in XLEN: predicted target.
- `bpu_use_ras` in 1: when high, the predicted target is `ras_top` instead of `bpu_pc`.
- `ras_push` in 1: call seen; push `ras_push_addr`.
- `ras_push_addr` in XLEN: return address to push.
- `ras_pop` in 1: return seen; pop the stack.
- `fetch_ready` in 1: IFU accepts the current group.
- `fetch_valid` out 1: a group is offered.
- `fetch_pc` out XLEN: address of the first valid slot.
- `fetch_mask` out FETCH_W: slot-valid mask. Bit i corresponds to slot i.
- `redirect_o` out 1: the current group is the first one after reset or after a redirect.
- `ras_top` out XLEN: top-of-stack entry, or 0 when empty.
- `ras_empty` out 1: stack is empty.

## Operation
- `pc` register. The current group base is `pc & ~(G-1)`; the slot index is `pc[log2(G)-1:2]`.
- `fetch_mask` has bits set from the slot index up to `FETCH_W-1`. Example: `FETCH_W=2` gives 2'b11 for an aligned pc and 2'b10 for pc at offset 4.
- Next-pc priority, evaluated each cycle:
  1. `trap_valid`: next pc = `trap_pc`.
  2. `flush_valid`: next pc = `flush_pc`.
  3. `bpu_valid` & `fetch_valid` & `fetch_ready`: next pc = `bpu_use_ras ? ras_top : bpu_pc`.
  4. `fetch_valid` & `fetch_ready`: next pc = group base + G.
  5. Otherwise pc holds.
- Redirect targets are forced to bits [1:0] = 0.
- Arithmetic is modulo 2^XLEN: base + G wraps from 0xFFFF_FFF8 to 0x0.
- Trap and flush apply regardless of `fetch_ready`. `bpu_valid` without a handshake is ignored.
- `redirect_o` is 1 in the cycle after:
  - any trap or flush,
  - any applied bpu redirect,
  - the first edge after reset release.
  It is otherwise 0, and holds its value while the group is stalled.
- `fetch_valid` is 0 in reset and 1 from the first edge after reset release onward. There is no internal bubble on redirect; the IFU discards the old group using `redirect_o`.
- RAS structure: circular buffer with a top pointer and a saturating count in 0..`RAS_DEPTH`.
- RAS operations:
  - Push only: write above top. If already full, overwrite the oldest entry; count stays at `RAS_DEPTH`.
  - Pop only: decrement. Pop on empty is a no-op.
  - Push and pop together: replace the top entry with `ras_push_addr`. If the stack is empty, this acts as a push.
  - `bpu_use_ras` reads `ras_top` before any same-cycle pop/push takes effect.
- Trap or flush empties the RAS (count := 0) and ignores same-cycle push/pop.

## Timing
- Async reset state:
  - `fetch_valid`=0, `fetch_pc`=`PC_INIT`, `redirect_o`=0, `ras_empty`=1, `ras_top`=0, count=0.
  - Outputs take these values immediately on `rst_n` falling, without waiting for an edge.
- First edge with `rst_n`=1: `fetch_valid`=1, `fetch_pc`=`PC_INIT`, `redirect_o`=1.
- Redirect latency: a request sampled at edge N is visible on `fetch_pc` after edge N (1 cycle).
- Handshake: the group advances only on an edge where `fetch_valid & fetch_ready`. `fetch_pc` and `fetch_mask` are stable while `fetch_ready`=0.
- Simultaneous trap, flush and bpu: trap wins. Flush beats bpu.
- Reset mid-stall or mid-redirect: pending state is lost; restart at `PC_INIT`.

## Test plan
All scenarios use `FETCH_W`=2, `PC_INIT`=0x8000_0000, `RAS_DEPTH`=4.
1. Release reset, hold `fetch_ready`=1 → groups 0x8000_0000 (mask 11, `redirect_o`=1), 0x8000_0008 (mask 11, `redirect_o`=0), 0x8000_0010.
2. Pulse `flush_valid` with `flush_pc`=0x8000_0106 → next group `fetch_pc`=0x8000_0104, mask 10, `redirect_o`=1; then 0x8000_0108, mask 11.
3. Stall: `fetch_ready`=0 for 3 cycles with `bpu_valid`=1, `bpu_pc`=0x9000_0000 → `fetch_pc` is unchanged for all 3 cycles; the prediction is ignored. Raise `fetch_ready` → pc steps to group base + 8.
4. Priority: one cycle with `trap_pc`=0x100, `flush_pc`=0x200 and `bpu_valid` with 0x300, plus a handshake → `fetch_pc`=0x100 and the RAS is empty.
5. RAS:
   - Push A1..A5 → `ras_top`=A5.
   - Pops return A5, A4, A3, A2, then `ras_empty`=1 and `ras_top`=0.
   - Pop on empty → no change.
   - Push A1, then `bpu_valid` with `bpu_use_ras` → next `fetch_pc`=A1.
6. Drive `rst_n` low between edges during a stall with the RAS holding 2 entries → immediately `fetch_valid`=0, `fetch_pc`=0x8000_0000, `ras_empty`=1. Release → scenario 1 sequence.

Source files
------------

// File: rtl/ysyx_pcgen.sv
// ysyx_pcgen: front-end program-counter generator.
// Offers aligned fetch groups of FETCH_W instructions to the IFU. Redirects
// come from trap, commit flush and branch prediction, in that priority order.
// A small circular return-address stack supplies predicted return targets.
//
// Handshake: a group is transferred on a rising edge where fetch_valid and
// fetch_ready are both high. While fetch_valid is high and fetch_ready is low,
// fetch_pc, fetch_mask and redirect_o hold their values. fetch_valid never
// drops after reset release. A redirect does not insert a bubble; redirect_o
// marks the first group on the new path so the IFU can drop the old one.
module ysyx_pcgen #(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   PC_INIT   = 'h8000_0000,
  parameter int                FETCH_W   = 2,
  parameter int                RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trap_valid,
  input  logic [XLEN-1:0]    trap_pc,
  input  logic               flush_valid,
  input  logic [XLEN-1:0]    flush_pc,
  input  logic               bpu_valid,
  input  logic [XLEN-1:0]    bpu_pc,
  input  logic               bpu_use_ras,
  input  logic               ras_push,
  input  logic [XLEN-1:0]    ras_push_addr,
  input  logic               ras_pop,
  input  logic               fetch_ready,
  output logic               fetch_valid,
  output logic [XLEN-1:0]    fetch_pc,
  output logic [FETCH_W-1:0] fetch_mask,
  output logic               redirect_o,
  output logic [XLEN-1:0]    ras_top,
  output logic               ras_empty
);

  localparam int G  = FETCH_W * 4;
  localparam int GB = $clog2(G);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] GROUP_MASK = ~XLEN'(G - 1);
  localparam logic [XLEN-1:0] GROUP_INC  = XLEN'(G);
  localparam logic [CW-1:0]   RAS_FULL   = CW'(RAS_DEPTH);

  // Program counter and fetch-side state
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q;
  logic            redir_q, redir_d;
  logic            hs;
  logic [XLEN-1:0] group_base;
  logic [XLEN-1:0] bpu_tgt;
  logic            kill;

  // Return-address stack state
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   tp_q, tp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;

  assign hs         = valid_q & fetch_ready;
  assign group_base = pc_q & GROUP_MASK;
  assign kill       = trap_valid | flush_valid;
  // Prediction reads the top entry as it stands before this cycle's push/pop.
  assign bpu_tgt    = bpu_use_ras ? ras_top : bpu_pc;

  assign fetch_valid = valid_q;
  assign fetch_pc    = pc_q;
  assign redirect_o  = redir_q;
  assign ras_empty   = (cnt_q == '0);
  assign ras_top     = ras_empty ? '0 : ras_mem[tp_q];

  // Slot mask: every slot from the pc's slot index up to the end of the group.
  generate
    if (FETCH_W == 1) begin : g_mask_single
      assign fetch_mask = 1'b1;
    end else begin : g_mask_multi
      logic [GB-3:0] slot;
      assign slot = pc_q[GB-1:2];
      // Set bits at and above the starting slot
      always_comb begin
        fetch_mask = '0;
        for (int i = 0; i < FETCH_W; i++) begin
          fetch_mask[i] = ((GB-2)'(i) >= slot);
        end
      end
    end
  endgenerate

  // Next-pc selection: trap > flush > taken prediction > sequential > hold
  always_comb begin
    pc_d    = pc_q;
    redir_d = redir_q;
    if (!valid_q) begin
      redir_d = 1'b1;
    end
    if (trap_valid) begin
      pc_d    = trap_pc & ALIGN_MASK;
      redir_d = 1'b1;
    end else if (flush_valid) begin
      pc_d    = flush_pc & ALIGN_MASK;
      redir_d = 1'b1;
    end else if (hs && bpu_valid) begin
      pc_d    = bpu_tgt & ALIGN_MASK;
      redir_d = 1'b1;
    end else if (hs) begin
      pc_d    = group_base + GROUP_INC;
      redir_d = 1'b0;
    end
  end

  // Fetch state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= PC_INIT;
      valid_q <= 1'b0;
      redir_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      redir_q <= redir_d;
    end
  end

  // RAS pointer/count update; push+pop replaces top, full push drops oldest
  always_comb begin
    tp_d   = tp_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = tp_q;
    if (kill) begin
      cnt_d = '0;
    end else if (ras_push && (!ras_pop || ras_empty)) begin
      tp_d   = tp_q + PW'(1);
      wr_idx = tp_q + PW'(1);
      wr_en  = 1'b1;
      if (cnt_q != RAS_FULL) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (ras_push && ras_pop) begin
      wr_en  = 1'b1;
      wr_idx = tp_q;
    end else if (ras_pop && !ras_empty) begin
      tp_d  = tp_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  // RAS pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
  end

  // RAS storage; contents are qualified by the count so no reset is needed
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ras_mem[wr_idx] <= ras_push_addr;
    end
  end

endmodule
